// File: rtl/pipe_hazard_seq_if.sv
// Hazard-sequencer bundle: hazard detector requests in, pipeline-register controls out.
// master = hazard detector / pipeline side, slave = pipe_hazard_seq.
interface pipe_hazard_seq_if;
    logic [1:0]  is_stall;
    logic [31:0] pc_branch;
    logic        mc_start;
    logic        mc_done;
    logic        pc_we;
    logic        pc_sel;
    logic [31:0] pc_target;
    logic        if_id_we;
    logic        if_id_flush;
    logic        id_ex_we;
    logic        id_ex_flush;
    logic        ex_mem_bubble;
    logic        mc_req;
    logic        mc_err;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    modport master (
        output is_stall, pc_branch, mc_start, mc_done,
        input  pc_we, pc_sel, pc_target, if_id_we, if_id_flush, id_ex_we,
               id_ex_flush, ex_mem_bubble, mc_req, mc_err, stall_cnt, flush_cnt
    );

    modport slave (
        input  is_stall, pc_branch, mc_start, mc_done,
        output pc_we, pc_sel, pc_target, if_id_we, if_id_flush, id_ex_we,
               id_ex_flush, ex_mem_bubble, mc_req, mc_err, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_seq.sv
// Pipeline hazard sequencer: redirect bubbles, load-use freeze, multi-cycle EX handshake.
// Optional perf counters enabled by defining HAZARD_PERF_CNT_EN.
module pipe_hazard_seq #(
    parameter int unsigned REDIRECT_BUBBLES = 2,
    parameter int unsigned MC_TIMEOUT       = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    pipe_hazard_seq_if.slave hz
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        REDIRECT = 2'd1,
        MC_WAIT  = 2'd2
    } state_t;

    state_t      state;
    logic [2:0]  bub_cnt;
    logic [7:0]  mc_cnt;
    logic        mc_req_q;
    logic        mc_err_q;
    logic [31:0] pc_target_q;

    logic        pc_we_c;
    logic        pc_sel_c;
    logic        if_id_we_c;
    logic        if_id_flush_c;
    logic        id_ex_we_c;
    logic        id_ex_flush_c;
    logic        ex_mem_bubble_c;
    logic        redirect_now;

    assign redirect_now = rst_n && (state == RUN) && hz.is_stall[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RUN;
            bub_cnt     <= '0;
            mc_cnt      <= '0;
            mc_req_q    <= 1'b0;
            mc_err_q    <= 1'b0;
            pc_target_q <= '0;
        end else begin
            case (state)
                RUN: begin
                    if (hz.is_stall[1]) begin
                        pc_target_q <= hz.pc_branch;
                        if (REDIRECT_BUBBLES > 1) begin
                            state   <= REDIRECT;
                            bub_cnt <= 3'(REDIRECT_BUBBLES - 1);
                        end
                    end else if (hz.mc_start) begin
                        state    <= MC_WAIT;
                        mc_req_q <= 1'b1;
                        mc_cnt   <= '0;
                    end
                end
                REDIRECT: begin
                    if (bub_cnt == 3'd1) begin
                        state <= RUN;
                    end else begin
                        bub_cnt <= bub_cnt - 3'd1;
                    end
                end
                MC_WAIT: begin
                    // a done in the last allowed cycle still wins over the timeout
                    if (hz.mc_done) begin
                        state    <= RUN;
                        mc_req_q <= 1'b0;
                    end else if (mc_cnt == 8'(MC_TIMEOUT - 1)) begin
                        state    <= RUN;
                        mc_req_q <= 1'b0;
                        mc_err_q <= 1'b1;
                    end else begin
                        mc_cnt <= mc_cnt + 8'd1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    always_comb begin
        pc_we_c         = 1'b1;
        pc_sel_c        = 1'b0;
        if_id_we_c      = 1'b1;
        if_id_flush_c   = 1'b0;
        id_ex_we_c      = 1'b1;
        id_ex_flush_c   = 1'b0;
        ex_mem_bubble_c = 1'b0;
        if (!rst_n) begin
            pc_we_c         = 1'b0;
            if_id_we_c      = 1'b0;
            id_ex_we_c      = 1'b0;
            if_id_flush_c   = 1'b1;
            id_ex_flush_c   = 1'b1;
            ex_mem_bubble_c = 1'b1;
        end else begin
            case (state)
                RUN: begin
                    if (hz.is_stall[1]) begin
                        pc_sel_c      = 1'b1;
                        if_id_flush_c = 1'b1;
                        id_ex_flush_c = 1'b1;
                    end else if (hz.mc_start) begin
                        pc_we_c         = 1'b0;
                        if_id_we_c      = 1'b0;
                        id_ex_we_c      = 1'b0;
                        ex_mem_bubble_c = 1'b1;
                    end else if (hz.is_stall[0]) begin
                        pc_we_c       = 1'b0;
                        if_id_we_c    = 1'b0;
                        id_ex_flush_c = 1'b1;
                    end
                end
                REDIRECT: if_id_flush_c = 1'b1;
                MC_WAIT: begin
                    if (!hz.mc_done) begin
                        pc_we_c         = 1'b0;
                        if_id_we_c      = 1'b0;
                        id_ex_we_c      = 1'b0;
                        ex_mem_bubble_c = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign hz.pc_we         = pc_we_c;
    assign hz.pc_sel        = pc_sel_c;
    assign hz.pc_target     = redirect_now ? hz.pc_branch : pc_target_q;
    assign hz.if_id_we      = if_id_we_c;
    assign hz.if_id_flush   = if_id_flush_c;
    assign hz.id_ex_we      = id_ex_we_c;
    assign hz.id_ex_flush   = id_ex_flush_c;
    assign hz.ex_mem_bubble = ex_mem_bubble_c;
    assign hz.mc_req        = mc_req_q;
    assign hz.mc_err        = mc_err_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (!pc_we_c) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            flush_cnt_q <= flush_cnt_q + 32'(if_id_flush_c) + 32'(id_ex_flush_c)
                         + 32'(ex_mem_bubble_c);
        end
    end

    assign hz.stall_cnt = stall_cnt_q;
    assign hz.flush_cnt = flush_cnt_q;
`else
    assign hz.stall_cnt = '0;
    assign hz.flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_seq.sv
// Randomized + directed bench for pipe_hazard_seq against a cycle-level reference model.
// Perf-counter expectations follow HAZARD_PERF_CNT_EN.
module tb_pipe_hazard_seq;

    localparam int RB = 2;
    localparam int MT = 6;

    logic clk = 1'b0;
    logic rst_n;

    pipe_hazard_seq_if hz ();

    pipe_hazard_seq #(
        .REDIRECT_BUBBLES(RB),
        .MC_TIMEOUT      (MT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .hz   (hz)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // reference model state: remaining redirect-bubble cycles, pending mul/div op
    int          red_left;
    bit          in_mc;
    int          mc_age;
    bit          err;
    logic [31:0] tgt;
    logic [31:0] sc;
    logic [31:0] fc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        red_left = 0;
        in_mc    = 1'b0;
        mc_age   = 0;
        err      = 1'b0;
        tgt      = '0;
        sc       = '0;
        fc       = '0;
    endtask

    task automatic check_reset_outputs();
        check("rst_pc_we",     hz.pc_we,         0);
        check("rst_pc_sel",    hz.pc_sel,        0);
        check("rst_if_id_we",  hz.if_id_we,      0);
        check("rst_id_ex_we",  hz.id_ex_we,      0);
        check("rst_if_id_fl",  hz.if_id_flush,   1);
        check("rst_id_ex_fl",  hz.id_ex_flush,   1);
        check("rst_bubble",    hz.ex_mem_bubble, 1);
        check("rst_mc_req",    hz.mc_req,        0);
        check("rst_mc_err",    hz.mc_err,        0);
        check("rst_pc_target", hz.pc_target,     0);
        check("rst_stall_cnt", hz.stall_cnt,     0);
        check("rst_flush_cnt", hz.flush_cnt,     0);
    endtask

    task automatic drive_idle();
        hz.is_stall  = 2'b00;
        hz.pc_branch = '0;
        hz.mc_start  = 1'b0;
        hz.mc_done   = 1'b0;
    endtask

    // one clock cycle: drive, compare against the model, then advance the model
    task automatic step(input logic [1:0] st, input logic [31:0] br, input logic s, input logic d);
        logic        e_we_pc, e_sel, e_we_ifid, e_we_idex, e_fl_ifid, e_fl_idex, e_bub;
        logic [31:0] e_tgt;
        @(negedge clk);
        hz.is_stall  = st;
        hz.pc_branch = br;
        hz.mc_start  = s;
        hz.mc_done   = d;
        #1;
        e_we_pc = 1; e_sel = 0; e_we_ifid = 1; e_we_idex = 1;
        e_fl_ifid = 0; e_fl_idex = 0; e_bub = 0;
        e_tgt = tgt;
        check("mc_req", hz.mc_req, in_mc);
        check("mc_err", hz.mc_err, err);
`ifdef HAZARD_PERF_CNT_EN
        check("stall_cnt", hz.stall_cnt, sc);
        check("flush_cnt", hz.flush_cnt, fc);
`else
        check("stall_cnt", hz.stall_cnt, 0);
        check("flush_cnt", hz.flush_cnt, 0);
`endif
        if (in_mc) begin
            if (d) begin
                in_mc = 1'b0;
            end else begin
                e_we_pc = 0; e_we_ifid = 0; e_we_idex = 0; e_bub = 1;
                mc_age++;
                if (mc_age == MT) begin
                    err   = 1'b1;
                    in_mc = 1'b0;
                end
            end
        end else if (red_left > 0) begin
            e_fl_ifid = 1;
            red_left--;
        end else if (st[1]) begin
            e_sel = 1; e_fl_ifid = 1; e_fl_idex = 1;
            e_tgt = br;
            tgt = br;
            red_left = RB - 1;
        end else if (s) begin
            e_we_pc = 0; e_we_ifid = 0; e_we_idex = 0; e_bub = 1;
            in_mc  = 1'b1;
            mc_age = 0;
        end else if (st[0]) begin
            e_we_pc = 0; e_we_ifid = 0; e_fl_idex = 1;
        end
        check("pc_we",         hz.pc_we,         e_we_pc);
        check("pc_sel",        hz.pc_sel,        e_sel);
        check("pc_target",     hz.pc_target,     e_tgt);
        check("if_id_we",      hz.if_id_we,      e_we_ifid);
        check("if_id_flush",   hz.if_id_flush,   e_fl_ifid);
        check("id_ex_we",      hz.id_ex_we,      e_we_idex);
        check("id_ex_flush",   hz.id_ex_flush,   e_fl_idex);
        check("ex_mem_bubble", hz.ex_mem_bubble, e_bub);
        if (!e_we_pc) sc = sc + 1;
        fc = fc + 32'(e_fl_ifid) + 32'(e_fl_idex) + 32'(e_bub);
    endtask

    // asynchronous reset dropped in the middle of a cycle
    task automatic reset_mid();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs();
        drive_idle();
        @(posedge clk);
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        logic [1:0]  r_st;
        logic [31:0] r_br;
        logic        r_s, r_d;
        rst_n = 1'b0;
        drive_idle();
        model_reset();
        #12;
        check_reset_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        // redirect to 0x100 with two bubble cycles
        step(2'b10, 32'h0000_0100, 1'b0, 1'b0);
        step(2'b00, 32'h0, 1'b0, 1'b0);
        check("redir_target_hold", hz.pc_target, 32'h0000_0100);
        step(2'b00, 32'h0, 1'b0, 1'b0);
        // single-cycle load-use stall
        step(2'b01, 32'h0, 1'b0, 1'b0);
        step(2'b00, 32'h0, 1'b0, 1'b0);
        // multi-cycle op, done five cycles after start
        step(2'b00, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(2'b00, 32'h0, 1'b0, 1'b0);
        step(2'b00, 32'h0, 1'b0, 1'b1);
        step(2'b01, 32'h0, 1'b0, 1'b0);
        // redirect together with load-use and mc_start
        step(2'b11, 32'hDEAD_BEE0, 1'b1, 1'b0);
        step(2'b00, 32'h0, 1'b0, 1'b0);
        step(2'b00, 32'h0, 1'b0, 1'b0);
        // timeout, then a late done that must be ignored
        step(2'b01, 32'h0, 1'b1, 1'b0);
        for (int i = 0; i < MT + 1; i++) step(2'b00, 32'h0, 1'b0, 1'b0);
        step(2'b00, 32'h0, 1'b0, 1'b1);
        step(2'b00, 32'h0, 1'b0, 1'b0);
        check("timeout_err_sticky", hz.mc_err, 1);
        // reset in the middle of MC_WAIT
        step(2'b00, 32'h0, 1'b1, 1'b0);
        step(2'b00, 32'h0, 1'b0, 1'b0);
        reset_mid();
        step(2'b00, 32'h0, 1'b0, 1'b0);

        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(99) == 0) begin
                reset_mid();
            end else begin
                r_st = {($urandom_range(3) == 0), ($urandom_range(3) == 0)};
                r_br = $urandom & 32'hFFFF_FFFC;
                r_s  = ($urandom_range(4) == 0);
                r_d  = ($urandom_range(3) == 0);
                step(r_st, r_br, r_s, r_d);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
